c3_window_gen: RTL and testbench
================================

Name: c3_window_gen

Overview:
- Downstream of the first layer (C1 conv + S2 pool). Starts once the six 14x14 pooled maps are complete in the L2 output block memories.
- Reads those maps and presents the C3 MAC array with one 5x5x6 window per output position, over a 10x10 grid.
- Keeps a 5-column sliding register per channel, so each output position in a row costs only one new column of reads.

Parameters:
- DATA_WIDTH, 12, pixel width, signed two's complement.
- MAP_DIM, 14, pooled map height/width.
- K, 5, kernel size.
- OUT_DIM, 10, output grid size; must equal MAP_DIM-K+1.
- N_CH, 6, input channels.
- RD_LAT, 2, block-memory read latency in cycles (address to data).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- en, in, 1, level enable; low forces IDLE.
- rd_addr, out, 8, shared read address to all six L2 memories; value = row*MAP_DIM+col.
- rd_data, in, N_CH*DATA_WIDTH, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- win_valid, out, 1, window valid.
- win_ready, in, 1, consumer accepts window.
- window, out, N_CH*K*K*DATA_WIDTH, tap (c,ky,kx) at bit offset ((c*K+ky)*K+kx)*DATA_WIDTH; kx=0 is the leftmost column.
- win_row, out, 4, output row of the current window.
- win_col, out, 4, output column of the current window.
- done, out, 1, all OUT_DIM*OUT_DIM windows accepted.

Behaviour:
- Reset values: rd_addr=0, win_valid=0, window=0, win_row=0, win_col=0, done=0; state IDLE; read pipeline valid bits cleared.
- States:
  - IDLE -> FILL when en=1; win_row=win_col=0; cols_to_load=K.
  - FILL issues one read per cycle, column-major: for col j, rows ky=0..K-1. Address = (win_row+ky)*MAP_DIM + win_col + j_abs, where j_abs is the absolute column being loaded.
    - After the last issue -> DRAIN.
  - DRAIN waits RD_LAT cycles for in-flight data -> EMIT.
  - EMIT holds win_valid=1 with window and coordinates stable until win_ready=1.
  - On the handshake cycle:
    - if win_row=win_col=OUT_DIM-1 -> DONE;
    - else if win_col=OUT_DIM-1 -> win_col=0, win_row+1, cols_to_load=K, FILL;
    - else win_col+1, cols_to_load=1, FILL.
  - DONE: done=1, win_valid=0; held until en=0, then IDLE.
- Capture:
  - A tag pipeline of depth RD_LAT carries {valid, ky} alongside each read.
  - A tagged return writes rd_data into a staging column at row ky for all channels.
  - On ky=K-1 return, the window shifts left one column (kx0 dropped, kx1->kx0 ... ) and the staging column enters kx=K-1.
  - In a K-column fill, the first K-1 shifts discard the stale columns.
- Latency (RD_LAT=2):
  - First FILL cycle = t0. win_valid rises at t0+K*K+RD_LAT = t0+27.
  - After a mid-row handshake at cycle h, win_valid rises at h+1+K+RD_LAT = h+8.
  - win_valid is low in all non-EMIT cycles.
- Arithmetic:
  - Max address (MAP_DIM-1)*MAP_DIM+MAP_DIM-1 = 195, which fits 8 bits.
  - Row/column counters saturate by state transition, never wrap.
- Boundaries:
  - win_ready high outside EMIT is ignored.
  - win_ready held low stalls EMIT indefinitely with no reads issued.
  - en falling in any state: IDLE on the next clock; in-flight returns are discarded; win_valid and done drop to 0; window contents are kept but never re-presented without a fresh fill.
  - rst has priority over en.

Optional Feature:
- Macro: C3_WIN_RELU_EN.
- Defined: each captured pixel with sign bit set is written as 0, giving ReLU on S2 output at capture time with no added latency.
- Undefined: pixels are captured unchanged.
- No port or timing difference either way.

Decomposition:
- Package c3_pkg: DATA_WIDTH, MAP_DIM, K, OUT_DIM, N_CH, RD_LAT constants; state enum IDLE/FILL/DRAIN/EMIT/DONE; tap-offset function.
- Sub-module c3_addr_gen: owns win_row, win_col, the column/row-in-column issue counters, and rd_addr generation. The top level keeps the FSM, tag pipeline and window register.

Test Plan:
- Memory model returns ch*256+addr after RD_LAT=2; en=1, win_ready=1 -> first win_valid 27 cycles after the first FILL cycle; tap(0,0,0)=0, tap(0,4,4)=60, tap(5,0,0)=1280.
- Continue with win_ready=1 -> second window (0,1) valid 8 cycles after the first handshake; tap(0,0,0)=1, tap(0,4,4)=61; window (1,0) tap(0,0,0)=14.
- Full run -> exactly 100 handshakes; last window (9,9) has tap(0,0,0)=135 and tap(0,4,4)=195; done=1 the cycle after; rd_addr never exceeds 195.
- Hold win_ready=0 for 20 cycles at window (3,4) -> win_valid, window and coordinates stable, rd_addr unchanged; release -> accepted once, next window is (3,5).
- Drop en during FILL of window (2,0) -> IDLE next cycle, win_valid=0; reassert en -> restarts at (0,0) with correct first-window values.
- With C3_WIN_RELU_EN, memory returns 12'hFFF for ch 2 -> every ch-2 tap is 0; without the macro -> 12'hFFF.

Source files
------------

// File: rtl/c3_pkg.sv
// Shared constants, state encoding and window tap layout for the C3 window generator.
// Imported by c3_addr_gen and c3_window_gen.
package c3_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int MAP_DIM    = 14;
    localparam int K          = 5;
    localparam int OUT_DIM    = MAP_DIM - K + 1;
    localparam int N_CH       = 6;
    localparam int RD_LAT     = 2;

    localparam int ADDR_W = 8;
    localparam int WIN_W  = N_CH * K * K * DATA_WIDTH;

    typedef logic [2:0] kidx_t;
    typedef logic [3:0] pos_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        EMIT,
        DONE
    } state_t;

    // Bit offset of tap (c, ky, kx) in the flattened window bus.
    function automatic int tap_off(input int c, input int ky, input int kx);
        return ((c * K + ky) * K + kx) * DATA_WIDTH;
    endfunction

endpackage

// File: rtl/c3_addr_gen.sv
// Output-position and read-address generator for the C3 window generator.
// Ports: clk/rst, start (reset position), issue (one read this cycle),
//   step_col/step_row (advance after a handshake), rd_addr, win_row, win_col,
//   iss_ky (row-in-column of the current read), fill_last, last_col, last_row.
module c3_addr_gen
    import c3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              issue,
    input  logic              step_col,
    input  logic              step_row,
    output logic [ADDR_W-1:0] rd_addr,
    output pos_t              win_row,
    output pos_t              win_col,
    output kidx_t             iss_ky,
    output logic              fill_last,
    output logic              last_col,
    output logic              last_row
);

    // col_j is the window-relative column being loaded; a one-column
    // refill starts at K-1 so every fill ends at (K-1, K-1).
    kidx_t col_j;
    kidx_t row_k;

    logic [ADDR_W-1:0] map_row;
    logic [ADDR_W-1:0] map_col;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            win_row <= '0;
            win_col <= '0;
            col_j   <= '0;
            row_k   <= '0;
        end else if (step_row) begin
            win_row <= win_row + pos_t'(1);
            win_col <= '0;
            col_j   <= '0;
            row_k   <= '0;
        end else if (step_col) begin
            win_col <= win_col + pos_t'(1);
            col_j   <= kidx_t'(K - 1);
            row_k   <= '0;
        end else if (issue && !fill_last) begin
            if (row_k == kidx_t'(K - 1)) begin
                row_k <= '0;
                col_j <= col_j + kidx_t'(1);
            end else begin
                row_k <= row_k + kidx_t'(1);
            end
        end
    end

    assign fill_last = (col_j == kidx_t'(K - 1)) && (row_k == kidx_t'(K - 1));
    assign last_col  = (win_col == pos_t'(OUT_DIM - 1));
    assign last_row  = (win_row == pos_t'(OUT_DIM - 1));
    assign iss_ky    = row_k;

    assign map_row = ADDR_W'(win_row) + ADDR_W'(row_k);
    assign map_col = ADDR_W'(win_col) + ADDR_W'(col_j);
    assign rd_addr = map_row * ADDR_W'(MAP_DIM) + map_col;

endmodule

// File: rtl/c3_window_gen.sv
// C3 window generator: streams 5x5x6 windows over the 10x10 output grid from
// the pooled S2 maps, reading one new column per step with a sliding register.
// Ports: clk, rst (sync, active-high), en, rd_addr/rd_data (L2 memories),
//   win_valid/win_ready handshake, window, win_row, win_col, done.
// Build option: define C3_WIN_RELU_EN to clamp negative pixels to 0 on capture.
module c3_window_gen
    import c3_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic [N_CH*DATA_WIDTH-1:0] rd_data,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [WIN_W-1:0]           window,
    output logic [3:0]                 win_row,
    output logic [3:0]                 win_col,
    output logic                       done
);

    state_t state;
    logic [3:0] drain_cnt;

    logic start, issue, hs;
    logic step_col, step_row;
    logic fill_last, last_col, last_row;
    kidx_t iss_ky;

    logic [RD_LAT-1:0] tag_v;
    kidx_t tag_ky [RD_LAT];
    kidx_t ret_ky;
    logic ret_v;

    logic [DATA_WIDTH-1:0] cap_pix [N_CH];
    logic [DATA_WIDTH-1:0] stage [N_CH][K-1];
    logic [DATA_WIDTH-1:0] win_q [N_CH][K][K];

    assign start    = en && (state == IDLE);
    assign issue    = en && (state == FILL);
    assign hs       = en && (state == EMIT) && win_ready;
    assign step_col = hs && !last_col;
    assign step_row = hs && last_col && !last_row;

    c3_addr_gen u_addr (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .issue     (issue),
        .step_col  (step_col),
        .step_row  (step_row),
        .rd_addr   (rd_addr),
        .win_row   (win_row),
        .win_col   (win_col),
        .iss_ky    (iss_ky),
        .fill_last (fill_last),
        .last_col  (last_col),
        .last_row  (last_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            win_valid <= 1'b0;
            done      <= 1'b0;
        end else if (!en) begin
            state     <= IDLE;
            win_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FILL;
                end
                FILL: begin
                    if (fill_last) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'(RD_LAT - 1)) begin
                        state     <= EMIT;
                        win_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                EMIT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (last_row && last_col) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipeline runs in step with the memory read latency.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            tag_v <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_ky[i] <= '0;
            end
        end else begin
            tag_v[0]  <= issue;
            tag_ky[0] <= iss_ky;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ky[i] <= tag_ky[i-1];
            end
        end
    end

    assign ret_v  = tag_v[RD_LAT-1];
    assign ret_ky = tag_ky[RD_LAT-1];

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
`ifdef C3_WIN_RELU_EN
            cap_pix[c] = rd_data[c*DATA_WIDTH+DATA_WIDTH-1] ? '0
                       : rd_data[c*DATA_WIDTH +: DATA_WIDTH];
`else
            cap_pix[c] = rd_data[c*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
    end

    // Bottom-row return completes a column: shift left, new column at kx=K-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int r = 0; r < K - 1; r++) begin
                    stage[c][r] <= '0;
                end
                for (int y = 0; y < K; y++) begin
                    for (int x = 0; x < K; x++) begin
                        win_q[c][y][x] <= '0;
                    end
                end
            end
        end else if (en && ret_v) begin
            if (ret_ky == kidx_t'(K - 1)) begin
                for (int c = 0; c < N_CH; c++) begin
                    for (int y = 0; y < K; y++) begin
                        for (int x = 0; x < K - 1; x++) begin
                            win_q[c][y][x] <= win_q[c][y][x+1];
                        end
                    end
                    for (int y = 0; y < K - 1; y++) begin
                        win_q[c][y][K-1] <= stage[c][y];
                    end
                    win_q[c][K-1][K-1] <= cap_pix[c];
                end
            end else begin
                for (int c = 0; c < N_CH; c++) begin
                    for (int r = 0; r < K - 1; r++) begin
                        if (ret_ky == kidx_t'(r)) begin
                            stage[c][r] <= cap_pix[c];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        window = '0;
        for (int c = 0; c < N_CH; c++) begin
            for (int y = 0; y < K; y++) begin
                for (int x = 0; x < K; x++) begin
                    window[tap_off(c, y, x) +: DATA_WIDTH] = win_q[c][y][x];
                end
            end
        end
    end

endmodule

// File: tb/tb_c3_window_gen.sv
// Scoreboard bench for c3_window_gen: memory model, expected-window queue,
// handshake monitor, latency, stall, abort and done checks.
module tb_c3_window_gen;
    import c3_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int NADDR = MAP_DIM * MAP_DIM;

    typedef struct packed {
        logic [3:0]       r;
        logic [3:0]       c;
        logic [WIN_W-1:0] w;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en, win_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [N_CH*DW-1:0] rd_data;
    logic win_valid, done;
    logic [WIN_W-1:0] window;
    logic [3:0] win_row, win_col;

    always #5 clk = ~clk;

    c3_window_gen dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .window    (window),
        .win_row   (win_row),
        .win_col   (win_col),
        .done      (done)
    );

    logic [DW-1:0] mem [N_CH][NADDR];
    logic [ADDR_W-1:0] a1, a2;

    always @(posedge clk) begin
        a1 <= rd_addr;
        a2 <= a1;
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (int'(a2) < NADDR) rd_data[c*DW +: DW] = mem[c][a2];
        end
    end

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int max_addr = 0;
    int phase = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_win(input string nm, input logic [WIN_W-1:0] act,
                             input logic [WIN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < N_CH * K * K; i++) begin
                if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
                    $display("FAIL %s: tap %0d got %h expected %h",
                             nm, i, act[i*DW +: DW], exp[i*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    function automatic int tap_of(input logic [WIN_W-1:0] w, input int c,
                                  input int ky, input int kx);
        return int'(w[((c * K + ky) * K + kx) * DW +: DW]);
    endfunction

    function automatic logic [DW-1:0] model_pix(input int ch, input int addr);
        logic [DW-1:0] v;
        v = mem[ch][addr];
`ifdef C3_WIN_RELU_EN
        if (v[DW-1]) v = '0;
`endif
        return v;
    endfunction

    task automatic push_all();
        exp_t e;
        for (int r = 0; r < OUT_DIM; r++) begin
            for (int c = 0; c < OUT_DIM; c++) begin
                e.r = 4'(r);
                e.c = 4'(c);
                e.w = '0;
                for (int ch = 0; ch < N_CH; ch++)
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++)
                            e.w[((ch * K + ky) * K + kx) * DW +: DW] =
                                model_pix(ch, (r + ky) * MAP_DIM + c + kx);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_mem(input bit pattern, input bit ch2_neg);
        for (int c = 0; c < N_CH; c++) begin
            for (int a = 0; a < NADDR; a++) begin
                if (pattern) mem[c][a] = DW'(c * 256 + a);
                else mem[c][a] = DW'($urandom_range(0, 4095));
                if (ch2_neg && c == 2) mem[c][a] = 12'hFFF;
            end
        end
    endtask

    // Monitor: pops the scoreboard on every accepted window.
    initial begin
        exp_t e;
        bit final_pending;
        final_pending = 0;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            if (final_pending) begin
                check("done_after_last", int'(done), 1);
                check("valid_after_last", int'(win_valid), 0);
                final_pending = 0;
            end
            if (win_valid && win_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("win_pos", int'({win_row, win_col}), int'({e.r, e.c}));
                    check_win("window", window, e.w);
                    if (phase == 1 && e.r == 0 && e.c == 0) begin
                        check("p1_w00_t000", tap_of(window, 0, 0, 0), 0);
                        check("p1_w00_t044", tap_of(window, 0, 4, 4), 60);
                        check("p1_w00_t500", tap_of(window, 5, 0, 0), 1280);
                    end
                    if (phase == 1 && e.r == 0 && e.c == 1) begin
                        check("p1_w01_t000", tap_of(window, 0, 0, 0), 1);
                        check("p1_w01_t044", tap_of(window, 0, 4, 4), 61);
                    end
                    if (phase == 1 && e.r == 1 && e.c == 0)
                        check("p1_w10_t000", tap_of(window, 0, 0, 0), 14);
                    if (phase == 1 && e.r == 9 && e.c == 9) begin
                        check("p1_w99_t000", tap_of(window, 0, 0, 0), 135);
                        check("p1_w99_t044", tap_of(window, 0, 4, 4), 195);
                    end
                    if (phase == 2 && e.r == 0 && e.c == 0) begin
`ifdef C3_WIN_RELU_EN
                        check("relu_ch2_t000", tap_of(window, 2, 0, 0), 0);
                        check("relu_ch2_t444", tap_of(window, 2, 4, 4), 0);
`else
                        check("raw_ch2_t000", tap_of(window, 2, 0, 0), 'hFFF);
                        check("raw_ch2_t444", tap_of(window, 2, 4, 4), 'hFFF);
`endif
                    end
                end
                if (win_row == 4'd9 && win_col == 4'd9) final_pending = 1;
            end
        end
    end

    task automatic run_random(input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            @(posedge clk); #1;
            n++;
            win_ready = ($urandom_range(0, 3) != 0);
        end
        check("run_timeout", int'(n < bound), 1);
    endtask

    task automatic drop_en();
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("en_low_valid", int'(win_valid), 0);
        check("en_low_done", int'(done), 0);
    endtask

    initial begin
        int k, n;
        bit stalled;
        logic [WIN_W-1:0] snap_w;
        logic [ADDR_W-1:0] snap_a;

        rst = 1'b1;
        en = 1'b0;
        win_ready = 1'b0;
        fill_mem(1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_valid", int'(win_valid), 0);
        check("rst_window", int'(window != '0), 0);
        check("rst_row", int'(win_row), 0);
        check("rst_col", int'(win_col), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;

        // Phase 1: counting pattern, consumer always ready.
        phase = 1;
        hs_cnt = 0;
        push_all();
        @(posedge clk); #1;
        en = 1'b1;
        win_ready = 1'b1;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        while (!win_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("first_latency", k, 27);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!win_valid && k < 100);
        check("step_latency", k, 8);
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("p1_timeout", int'(n < 5000), 1);
        @(negedge clk);
        check("p1_handshakes", hs_cnt, 100);
        check("p1_queue_empty", exp_q.size(), 0);
        drop_en();

        // Phase 2: random data, ch2 negative, random ready, stall at (3,4).
        phase = 2;
        fill_mem(0, 1);
        hs_cnt = 0;
        exp_q.delete();
        push_all();
        @(posedge clk); #1;
        en = 1'b1;
        stalled = 0;
        n = 0;
        while (!done && n < 20000) begin
            @(posedge clk); #1;
            n++;
            if (!stalled && win_valid && win_row == 4'd3 && win_col == 4'd4) begin
                stalled = 1;
                win_ready = 1'b0;
                snap_w = window;
                snap_a = rd_addr;
                repeat (20) begin
                    @(posedge clk); #1;
                    n++;
                    check("stall_hold", int'({win_valid, win_row, win_col, rd_addr}),
                          int'({1'b1, 4'd3, 4'd4, snap_a}));
                    check_win("stall_window", window, snap_w);
                end
                win_ready = 1'b1;
            end else begin
                win_ready = ($urandom_range(0, 3) != 0);
            end
        end
        check("p2_timeout", int'(n < 20000), 1);
        check("stall_reached", int'(stalled), 1);
        @(negedge clk);
        check("p2_handshakes", hs_cnt, 100);
        check("p2_queue_empty", exp_q.size(), 0);
        drop_en();

        // Phase 3: abort during FILL of (2,0), then restart from (0,0).
        phase = 3;
        fill_mem(0, 0);
        hs_cnt = 0;
        exp_q.delete();
        push_all();
        @(posedge clk); #1;
        en = 1'b1;
        n = 0;
        while (!(win_row == 4'd2 && win_col == 4'd0 && !win_valid) && n < 20000) begin
            @(posedge clk); #1;
            n++;
            win_ready = ($urandom_range(0, 3) != 0);
        end
        check("abort_reached", int'(n < 20000), 1);
        check("abort_hs_before", hs_cnt, 20);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", int'(win_valid), 0);
        check("abort_done", int'(done), 0);
        exp_q.delete();
        hs_cnt = 0;
        push_all();
        @(posedge clk); #1;
        en = 1'b1;
        run_random(20000);
        @(negedge clk);
        check("p3_handshakes", hs_cnt, 100);
        check("p3_queue_empty", exp_q.size(), 0);

        check("rd_addr_max_ok", int'(max_addr <= 195), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
